// File: rtl/lcd_st_timing_adapter_param.sv
// rtl/lcd_st_timing_adapter_param.sv - Avalon-ST timing adapter: ready-latency FIFO with drop accounting
module lcd_st_timing_adapter_param #(
   parameter int DATA_W            = 64,
   parameter int SYMBOLS           = 8,
   parameter int FIFO_DEPTH        = 8,
   parameter int IN_READY_LATENCY  = 1,
   parameter int OUT_READY_LATENCY = 0,
   localparam int EMPTY_W          = (SYMBOLS > 1) ? $clog2(SYMBOLS) : 1,
   localparam int CNT_W            = $clog2(FIFO_DEPTH) + 1
) (
   input  logic               clk,
   input  logic               reset,
   output logic               in_ready,
   input  logic               in_valid,
   input  logic [DATA_W-1:0]  in_data,
   input  logic               in_startofpacket,
   input  logic               in_endofpacket,
   input  logic [EMPTY_W-1:0] in_empty,
   input  logic               out_ready,
   output logic               out_valid,
   output logic [DATA_W-1:0]  out_data,
   output logic               out_startofpacket,
   output logic               out_endofpacket,
   output logic [EMPTY_W-1:0] out_empty,
   output logic [CNT_W-1:0]   fill_level,
   output logic               overflow,
   output logic [15:0]        drop_count
);

   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int ENTRY_W = DATA_W + 2 + EMPTY_W;
   localparam logic [CNT_W-1:0] FULL_C = CNT_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] RDY_C  = CNT_W'(FIFO_DEPTH - IN_READY_LATENCY);

   logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   wr_ptr;
   logic [CNT_W-1:0]   count;
   logic               pop;
   logic               wr_en;
   logic               drop;

   generate
      if (OUT_READY_LATENCY == 0) begin : g_rl0
         assign out_valid = (count != '0);
         assign pop       = out_valid & out_ready;
      end else begin : g_rln
         // out_ready delayed L cycles; a qualified cycle with data is a transfer
         logic [OUT_READY_LATENCY-1:0] rdy_sr;
         always_ff @(posedge clk) begin
            if (reset) begin
               rdy_sr <= '0;
            end else begin
               rdy_sr <= (rdy_sr << 1) | OUT_READY_LATENCY'(out_ready);
            end
         end
         assign out_valid = rdy_sr[OUT_READY_LATENCY-1] & (count != '0);
         assign pop       = out_valid;
      end
   endgenerate

   // The source already honours in_ready latency, so in_valid alone requests a write
   assign wr_en = in_valid & ((count != FULL_C) | pop);
   assign drop  = in_valid & ~wr_en;

   assign in_ready   = (count < RDY_C);
   assign fill_level = count;
   assign {out_data, out_startofpacket, out_endofpacket, out_empty} = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= {in_data, in_startofpacket, in_endofpacket, in_empty};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         overflow   <= 1'b0;
         drop_count <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({wr_en, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 16'hFFFF) begin
               drop_count <= drop_count + 16'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_lcd_st_timing_adapter_param.sv
// tb/tb_lcd_st_timing_adapter_param.sv - self-checking bench for lcd_st_timing_adapter_param
module tb_lcd_st_timing_adapter_param;

   logic        clk = 1'b0;
   logic        reset = 1'b1;

   logic        a_in_ready, a_in_valid, a_sop, a_eop, a_out_ready, a_out_valid, a_osop, a_oeop, a_ovf;
   logic [63:0] a_in_data, a_out_data;
   logic [2:0]  a_empty, a_oempty;
   logic [3:0]  a_fill;
   logic [15:0] a_drop;

   logic        b_in_ready, b_in_valid, b_sop, b_eop, b_out_ready, b_out_valid, b_osop, b_oeop, b_ovf;
   logic [63:0] b_in_data, b_out_data;
   logic [2:0]  b_empty, b_oempty;
   logic [3:0]  b_fill;
   logic [15:0] b_drop;

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   lcd_st_timing_adapter_param #(.OUT_READY_LATENCY(0)) dut_a (
      .clk(clk), .reset(reset), .in_ready(a_in_ready), .in_valid(a_in_valid), .in_data(a_in_data),
      .in_startofpacket(a_sop), .in_endofpacket(a_eop), .in_empty(a_empty), .out_ready(a_out_ready),
      .out_valid(a_out_valid), .out_data(a_out_data), .out_startofpacket(a_osop),
      .out_endofpacket(a_oeop), .out_empty(a_oempty), .fill_level(a_fill), .overflow(a_ovf),
      .drop_count(a_drop));

   lcd_st_timing_adapter_param #(.OUT_READY_LATENCY(2)) dut_b (
      .clk(clk), .reset(reset), .in_ready(b_in_ready), .in_valid(b_in_valid), .in_data(b_in_data),
      .in_startofpacket(b_sop), .in_endofpacket(b_eop), .in_empty(b_empty), .out_ready(b_out_ready),
      .out_valid(b_out_valid), .out_data(b_out_data), .out_startofpacket(b_osop),
      .out_endofpacket(b_oeop), .out_empty(b_oempty), .fill_level(b_fill), .overflow(b_ovf),
      .drop_count(b_drop));

   typedef struct {
      logic        iv;
      logic [63:0] d;
      logic        sop;
      logic        eop;
      logic [2:0]  emp;
      logic        e_ov;
      logic [63:0] e_d;
      logic        e_sop;
      logic        e_eop;
      logic [2:0]  e_emp;
      logic [3:0]  e_fill;
   } vec_t;

   vec_t vt[4];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act !== exp) begin
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         pass_cnt++;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   logic [63:0] eq[$];
   logic [66:0] mq[$];
   int          first_low;
   int          rdy_prev;
   int          cur_rdy;
   int          mdrop;
   logic        mpop, macc, iv, orr;
   logic [66:0] beat;

   initial begin
      vt[0] = '{1'b1, 64'h11, 1'b1, 1'b0, 3'd0, 1'b1, 64'h11, 1'b1, 1'b0, 3'd0, 4'd1};
      vt[1] = '{1'b1, 64'h22, 1'b0, 1'b0, 3'd0, 1'b1, 64'h22, 1'b0, 1'b0, 3'd0, 4'd1};
      vt[2] = '{1'b1, 64'h33, 1'b0, 1'b1, 3'd5, 1'b1, 64'h33, 1'b0, 1'b1, 3'd5, 4'd1};
      vt[3] = '{1'b0, 64'h0,  1'b0, 1'b0, 3'd0, 1'b0, 64'h0,  1'b0, 1'b0, 3'd0, 4'd0};

      a_in_valid = 0; a_in_data = '0; a_sop = 0; a_eop = 0; a_empty = '0; a_out_ready = 0;
      b_in_valid = 0; b_in_data = '0; b_sop = 0; b_eop = 0; b_empty = '0; b_out_ready = 0;
      do_reset();

      check("reset_fill", 64'(a_fill), 64'd0);
      check("reset_in_ready", 64'(a_in_ready), 64'd1);
      check("reset_out_valid", 64'(a_out_valid), 64'd0);
      check("reset_overflow", 64'(a_ovf), 64'd0);
      check("reset_drop", 64'(a_drop), 64'd0);

      // basic stream: each beat visible one cycle after it is written
      a_out_ready = 1;
      for (int i = 0; i < 4; i++) begin
         a_in_valid = vt[i].iv; a_in_data = vt[i].d; a_sop = vt[i].sop;
         a_eop = vt[i].eop; a_empty = vt[i].emp;
         step();
         check("basic_valid", 64'(a_out_valid), 64'(vt[i].e_ov));
         check("basic_fill", 64'(a_fill), 64'(vt[i].e_fill));
         if (vt[i].e_ov) begin
            check("basic_data", a_out_data, vt[i].e_d);
            check("basic_sop", 64'(a_osop), 64'(vt[i].e_sop));
            check("basic_eop", 64'(a_oeop), 64'(vt[i].e_eop));
            check("basic_empty", 64'(a_oempty), 64'(vt[i].e_emp));
         end
      end
      a_in_valid = 0; a_sop = 0; a_eop = 0; a_empty = '0;

      // fill with a latency-1 compliant source
      a_out_ready = 0;
      first_low = -1;
      rdy_prev = 1;
      for (int k = 0; k < 12; k++) begin
         a_in_valid = rdy_prev[0];
         a_in_data = 64'(k);
         if (rdy_prev != 0) eq.push_back(64'(k));
         cur_rdy = int'(a_in_ready);
         step();
         rdy_prev = cur_rdy;
         if (!a_in_ready && first_low < 0) first_low = int'(a_fill);
      end
      a_in_valid = 0;
      check("fill_ready_drop_at", 64'(first_low), 64'd7);
      check("fill_level_full", 64'(a_fill), 64'd8);
      check("fill_in_ready", 64'(a_in_ready), 64'd0);
      check("fill_overflow", 64'(a_ovf), 64'd0);
      check("fill_drop", 64'(a_drop), 64'd0);

      // overflow: three forced beats into the full FIFO
      for (int k = 0; k < 3; k++) begin
         a_in_valid = 1; a_in_data = 64'hDEAD_0000 + 64'(k);
         step();
      end
      a_in_valid = 0;
      check("ovf_drop", 64'(a_drop), 64'd3);
      check("ovf_flag", 64'(a_ovf), 64'd1);
      check("ovf_fill", 64'(a_fill), 64'd8);
      step();
      check("ovf_sticky", 64'(a_ovf), 64'd1);
      a_out_ready = 1;
      for (int k = 0; k < 8; k++) begin
         check("drain_valid", 64'(a_out_valid), 64'd1);
         check("drain_data", a_out_data, eq.pop_front());
         step();
      end
      check("drain_empty", 64'(a_out_valid), 64'd0);
      check("drain_ovf_sticky", 64'(a_ovf), 64'd1);
      check("drain_drop_hold", 64'(a_drop), 64'd3);

      // reset with five beats stored
      a_out_ready = 0;
      for (int k = 0; k < 5; k++) begin
         a_in_valid = 1; a_in_data = 64'h500 + 64'(k);
         step();
      end
      a_in_valid = 0;
      check("pre_reset_fill", 64'(a_fill), 64'd5);
      do_reset();
      check("mid_reset_fill", 64'(a_fill), 64'd0);
      check("mid_reset_valid", 64'(a_out_valid), 64'd0);
      check("mid_reset_in_ready", 64'(a_in_ready), 64'd1);
      check("mid_reset_ovf", 64'(a_ovf), 64'd0);
      check("mid_reset_drop", 64'(a_drop), 64'd0);
      a_out_ready = 1;
      step();
      check("post_reset_valid", 64'(a_out_valid), 64'd0);

      // simultaneous push and pop while full, across pointer wrap
      a_out_ready = 0;
      eq.delete();
      for (int k = 0; k < 8; k++) begin
         a_in_valid = 1; a_in_data = 64'd100 + 64'(k);
         eq.push_back(64'd100 + 64'(k));
         step();
      end
      check("pp_fill_start", 64'(a_fill), 64'd8);
      for (int j = 0; j < 20; j++) begin
         a_in_valid = 1; a_in_data = 64'd200 + 64'(j); a_out_ready = 1;
         check("pp_valid", 64'(a_out_valid), 64'd1);
         check("pp_data", a_out_data, eq.pop_front());
         eq.push_back(64'd200 + 64'(j));
         step();
         check("pp_fill", 64'(a_fill), 64'd8);
      end
      a_in_valid = 0;
      check("pp_drop", 64'(a_drop), 64'd0);
      for (int k = 0; k < 8; k++) begin
         check("pp_tail_data", a_out_data, eq.pop_front());
         step();
      end

      // randomized traffic against a queue model
      a_in_valid = 0; a_out_ready = 0;
      do_reset();
      mq.delete();
      mdrop = 0;
      for (int c = 0; c < 400; c++) begin
         iv  = ($urandom_range(0, 9) < 6);
         orr = ($urandom_range(0, 9) < 4);
         beat = {$urandom, $urandom, 3'($urandom)};
         a_in_valid = iv; a_out_ready = orr;
         {a_in_data, a_sop, a_eop, a_empty} = beat;
         check("rnd_valid", 64'(a_out_valid), 64'(mq.size() != 0));
         if (mq.size() != 0) check("rnd_payload", 64'({a_out_data, a_osop, a_oeop, a_oempty} ^ mq[0]), 64'd0);
         check("rnd_fill", 64'(a_fill), 64'(mq.size()));
         check("rnd_in_ready", 64'(a_in_ready), 64'(mq.size() < 7));
         check("rnd_drop", 64'(a_drop), 64'(mdrop));
         check("rnd_ovf", 64'(a_ovf), 64'(mdrop != 0));
         mpop = (mq.size() != 0) && orr;
         macc = iv && ((mq.size() < 8) || mpop);
         if (mpop) void'(mq.pop_front());
         if (macc) mq.push_back(beat);
         else if (iv && mdrop < 65535) mdrop++;
         step();
      end
      a_in_valid = 0; a_out_ready = 0;

      // output ready latency 2 on the second instance
      for (int cyc = 0; cyc < 18; cyc++) begin
         b_in_valid = (cyc < 4);
         b_in_data = 64'hA0 + 64'(cyc);
         b_out_ready = (cyc == 10 || cyc == 12);
         check("l2_valid", 64'(b_out_valid), 64'(cyc == 12 || cyc == 14));
         if (cyc == 12) check("l2_data0", b_out_data, 64'hA0);
         if (cyc == 14) check("l2_data1", b_out_data, 64'hA1);
         step();
      end
      check("l2_fill", 64'(b_fill), 64'd2);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
